alu_op_encoder: RTL

//  Decode stage feeding the ALU. Turns a 32-bit RV32I instruction into the 7-bit ALU opcode
//  (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl), operand selects, sign-extended immediate
//  and register indices. Registered, valid/ready on both sides, 2-entry skid so in_ready is a

---
 rtl/alu_op_encoder.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_encoder.sv
// rtl/alu_op_encoder.sv - RV32I decode stage producing ALU opcode, operand selects and immediate
// Optional illegal-bundle counter on illegal_cnt when ALU_DEC_STATS_EN is defined.
module alu_op_encoder #(
    parameter logic [6:0] ILLEGAL_OP = 7'd127
`ifdef ALU_DEC_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  alu_opcode,
    output logic        a_is_pc,
    output logic        a_is_zero,
    output logic        b_is_imm,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        br_en,
    output logic [2:0]  br_cond,
    output logic        illegal
`ifdef ALU_DEC_STATS_EN
    , output logic [CNT_W-1:0] illegal_cnt
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] ALU_ADD    = 7'd0;
    localparam logic [6:0] ALU_SUB    = 7'd1;
    localparam logic [6:0] ALU_AND    = 7'd2;
    localparam logic [6:0] ALU_OR     = 7'd3;
    localparam logic [6:0] ALU_XOR    = 7'd4;
    localparam logic [6:0] ALU_SLL    = 7'd5;
    localparam logic [6:0] ALU_SRL    = 7'd6;

    typedef struct packed {
        logic [6:0]  alu_opcode;
        logic        a_is_pc;
        logic        a_is_zero;
        logic        b_is_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        br_en;
        logic [2:0]  br_cond;
        logic        illegal;
    } bundle_t;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    bundle_t     raw, dec;
    logic        ok;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        raw       = '0;
        ok        = 1'b0;
        raw.rs1   = in_instr[19:15];
        raw.rs2   = in_instr[24:20];
        raw.rd    = in_instr[11:7];
        raw.rd_we = (in_instr[11:7] != 5'd0);
        case (opcode)
            OPC_OP: begin
                case (funct3)
                    3'b000: begin
                        ok = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        raw.alu_opcode = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    end
                    3'b111: begin ok = (funct7 == F7_ZERO); raw.alu_opcode = ALU_AND; end
                    3'b110: begin ok = (funct7 == F7_ZERO); raw.alu_opcode = ALU_OR;  end
                    3'b100: begin ok = (funct7 == F7_ZERO); raw.alu_opcode = ALU_XOR; end
                    3'b001: begin ok = (funct7 == F7_ZERO); raw.alu_opcode = ALU_SLL; end
                    3'b101: begin ok = (funct7 == F7_ZERO); raw.alu_opcode = ALU_SRL; end
                    default: ok = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                raw.b_is_imm = 1'b1;
                raw.imm      = imm_i;
                case (funct3)
                    3'b000: begin ok = 1'b1; raw.alu_opcode = ALU_ADD; end
                    3'b111: begin ok = 1'b1; raw.alu_opcode = ALU_AND; end
                    3'b110: begin ok = 1'b1; raw.alu_opcode = ALU_OR;  end
                    3'b100: begin ok = 1'b1; raw.alu_opcode = ALU_XOR; end
                    3'b001: begin ok = (funct7 == F7_ZERO); raw.alu_opcode = ALU_SLL; end
                    3'b101: begin ok = (funct7 == F7_ZERO); raw.alu_opcode = ALU_SRL; end
                    default: ok = 1'b0;
                endcase
            end
            OPC_LOAD, OPC_JALR: begin
                ok = 1'b1; raw.b_is_imm = 1'b1; raw.imm = imm_i;
            end
            OPC_STORE: begin
                ok = 1'b1; raw.b_is_imm = 1'b1; raw.imm = imm_s; raw.rd_we = 1'b0;
            end
            OPC_LUI: begin
                ok = 1'b1; raw.a_is_zero = 1'b1; raw.b_is_imm = 1'b1; raw.imm = imm_u;
            end
            OPC_AUIPC: begin
                ok = 1'b1; raw.a_is_pc = 1'b1; raw.b_is_imm = 1'b1; raw.imm = imm_u;
            end
            OPC_JAL: begin
                ok = 1'b1; raw.a_is_pc = 1'b1; raw.b_is_imm = 1'b1; raw.imm = imm_j;
            end
            OPC_BRANCH: begin
                // Only beq/bne/blt/bge map onto ZF/SF of a subtract.
                ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b101);
                raw.alu_opcode = ALU_SUB;
                raw.br_en      = 1'b1;
                raw.br_cond    = funct3;
                raw.imm        = imm_b;
                raw.rd_we      = 1'b0;
            end
            default: ok = 1'b0;
        endcase

        dec = raw;
        if (!ok) begin
            dec            = '0;
            dec.rs1        = raw.rs1;
            dec.rs2        = raw.rs2;
            dec.rd         = raw.rd;
            dec.alu_opcode = ILLEGAL_OP;
            dec.illegal    = 1'b1;
        end
    end

    bundle_t out_q, out_d, skid_q, skid_d;
    logic    out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
    logic    in_fire, out_free;

    assign in_fire  = in_valid && in_ready_q;
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_free) begin
            // A parked skid entry always goes out before anything newer.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) out_d = dec;
            end
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

`ifdef ALU_DEC_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q && out_ready && out_q.illegal && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign illegal_cnt = cnt_q;
`endif

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign alu_opcode = out_q.alu_opcode;
    assign a_is_pc    = out_q.a_is_pc;
    assign a_is_zero  = out_q.a_is_zero;
    assign b_is_imm   = out_q.b_is_imm;
    assign imm        = out_q.imm;
    assign rs1        = out_q.rs1;
    assign rs2        = out_q.rs2;
    assign rd         = out_q.rd;
    assign rd_we      = out_q.rd_we;
    assign br_en      = out_q.br_en;
    assign br_cond    = out_q.br_cond;
    assign illegal    = out_q.illegal;

endmodule
